tile_router_v1_00_a_input_port: RTL and testbench
=================================================

TILE_ROUTER_V1_00_A_INPUT_PORT -- requirements
Module: tile_router_v1_00_a_input_port

Interface
REQ-001 SHALL have parameter C_NUM_PORTS, default 8: number of router output ports fed by this input.
REQ-002 SHALL have parameter C_PACKET_WIDTH, default `PACKET_WIDTH: flit width in bits.
REQ-003 SHALL have parameter C_FIFO_DEPTH, default 16: input buffer depth in flits, power of 2.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port input_valid  input  1  upstream link flit valid.
REQ-007 SHALL have port input_accept  output  1  flit taken when input_valid & input_accept.
REQ-008 SHALL have port input_payload  input  C_PACKET_WIDTH  flit data.
REQ-009 SHALL have port portX_valid  output  C_NUM_PORTS  one-hot per-destination valid, bit i feeds output port i clientX_valid.
REQ-010 SHALL have port portX_accept  input  C_NUM_PORTS  per-destination accept from output port arbiters.
REQ-011 SHALL have port portX_payload  output  C_PACKET_WIDTH  flit data, shared by all destinations.
REQ-012 SHALL have port drop_count  output  16  count of discarded packets.

Function
REQ-013 Flit format SHALL be: bit `PKT_LAST_BIT = last flit of packet; head flit field [`PKT_DEST_LSB +: clog2(C_NUM_PORTS)] = destination port.
REQ-014 input_accept SHALL equal ~fifo_full & ~rst; accepted flits enter a first-word-fall-through FIFO in order.
REQ-015 A flit accepted in cycle N SHALL be visible at the FIFO head no earlier than cycle N+1.
REQ-016 FSM states SHALL be HEAD, FWD, DROP; reset state HEAD.
REQ-017 HEAD: when FIFO non-empty, latch destination of head flit into dest_r; go to DROP if destination invalid (REQ-027), else FWD; no flit popped, portX_valid = 0.
REQ-018 FWD: portX_valid = (~fifo_empty) << dest_r; all other bits 0; portX_payload = FIFO head.
REQ-019 FWD: flit popped iff ~fifo_empty & portX_accept[dest_r]; accept bits of other ports SHALL be ignored.
REQ-020 FWD: when popped flit has last = 1, next state HEAD; otherwise stay FWD (route locked for entire packet).
REQ-021 DROP: pop one flit per cycle while non-empty, portX_valid = 0; on popped last flit increment drop_count and go to HEAD.
REQ-022 Single-flit packet (head with last = 1) SHALL take HEAD then FWD, returning to HEAD on its accept: one bubble cycle per packet.
REQ-023 Simultaneous FIFO push and pop SHALL both occur; push allowed when full only if not full at start of cycle (no push-through-when-full).
REQ-024 drop_count SHALL saturate at 16'hFFFF.
REQ-025 portX_valid SHALL never have more than one bit set; once asserted for a flit it SHALL stay asserted with stable payload until accepted.

Reset
REQ-026 While rst = 1: FSM = HEAD, FIFO empty, dest_r = 0, drop_count = 0, portX_valid = 0, input_accept = 0; reset mid-packet discards all buffered flits and the partial route.

Configuration
REQ-027 Macro TILE_ROUTER_INPUT_DROP_EN: when defined, a head destination >= C_NUM_PORTS SHALL select DROP; when undefined, such a destination SHALL be routed to port C_NUM_PORTS-1, DROP is unreachable and drop_count is constant 0.

Structure
REQ-028 `PACKET_WIDTH, `PKT_LAST_BIT, `PKT_DEST_LSB and FSM state encodings SHALL live in shared tile_router_v1_00_a_defines.vh; clog2 from math.vh.
REQ-029 The buffer SHALL be one instance of existing fifo_fwft_prog_full (prog_full unused); FSM and steering in this module.

Verification
REQ-030 Reset, then single-flit packet dest=3 last=1, portX_accept all 1 -> portX_valid = 8'h08 exactly one cycle, payload matches, FSM back to HEAD.
REQ-031 4-flit packet dest=5, portX_accept[5] held 0 for 10 cycles -> portX_valid = 8'h20 held, payload stable, no pop; release -> 4 flits in order, portX_accept[2] toggling has no effect.
REQ-032 Push 16 flits with all accepts 0 -> input_accept drops to 0 after 16th; one pop -> input_accept = 1 next cycle; simultaneous push/pop keeps count at 16.
REQ-033 With TILE_ROUTER_INPUT_DROP_EN, C_NUM_PORTS=6, 3-flit packet dest=7 -> portX_valid stays 0, 3 flits popped, drop_count = 1; without macro -> packet delivered on port 5.
REQ-034 Assert rst mid-way through 4-flit packet (2 flits delivered) -> all outputs at reset values next cycle; subsequent packet dest=0 delivered correctly.

Source files
------------

// File: rtl/tile_router_v1_00_a_input_port_pkg.sv
// ---------------------------------------------------------------------------
// tile_router_v1_00_a_input_port_pkg
//
// Shared definitions for the tile router input port:
//   PACKET_WIDTH  - default flit width in bits
//   PKT_LAST_BIT  - bit position of the "last flit of packet" marker
//   PKT_DEST_LSB  - low bit of the destination field carried by head flits
//   STATE_*       - input port FSM state encodings
//   clog2()       - ceiling log2 used to size pointers and destination fields
//
// No ports; this is a package imported by the input port and its FIFO.
// ---------------------------------------------------------------------------
package tile_router_v1_00_a_input_port_pkg;

   localparam int PACKET_WIDTH = 32;
   localparam int PKT_LAST_BIT = 31;
   localparam int PKT_DEST_LSB = 24;

   typedef logic [1:0] state_t;

   localparam logic [1:0] STATE_HEAD = 2'd0;
   localparam logic [1:0] STATE_FWD  = 2'd1;
   localparam logic [1:0] STATE_DROP = 2'd2;

   // Smallest n such that 2**n >= value; clog2(1) is 0.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/tile_router_v1_00_a_input_port_fifo.sv
// ---------------------------------------------------------------------------
// fifo_fwft_prog_full
//
// First-word-fall-through FIFO with a programmable "almost full" flag.
// The head entry is always presented on o_rdData while o_empty is low, and
// a write performed on one rising edge becomes visible at the head only
// after that edge (no combinational write-to-read path).
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset, empties the FIFO
//   i_wrEn     - write request; ignored while o_full is high
//   i_wrData   - data to write
//   o_full     - FIFO holds C_DEPTH entries
//   o_progFull - FIFO holds at least C_PROG_FULL_THRESH entries
//   i_rdEn     - pop the head entry; ignored while o_empty is high
//   o_rdData   - current head entry
//   o_empty    - FIFO holds no entries
//
// C_DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module fifo_fwft_prog_full
   import tile_router_v1_00_a_input_port_pkg::*;
#(
   parameter int C_DATA_WIDTH       = 32,
   parameter int C_DEPTH            = 16,
   parameter int C_PROG_FULL_THRESH = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_wrEn,
   input  logic [C_DATA_WIDTH-1:0] i_wrData,
   output logic                    o_full,
   output logic                    o_progFull,
   input  logic                    i_rdEn,
   output logic [C_DATA_WIDTH-1:0] o_rdData,
   output logic                    o_empty
);

   localparam int PTR_W = clog2(C_DEPTH);

   localparam logic [PTR_W:0] DEPTH_COUNT  = C_DEPTH[PTR_W:0];
   localparam logic [PTR_W:0] THRESH_COUNT = C_PROG_FULL_THRESH[PTR_W:0];

   logic [C_DATA_WIDTH-1:0] r_mem [C_DEPTH];

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PTR_W:0] r_wrPtr;
   logic [PTR_W:0] r_rdPtr;
   logic [PTR_W:0] w_count;
   logic           w_push;
   logic           w_pop;

   // Fullness is judged on the registered count, so a pop in the same cycle
   // never makes room for a push into an already full buffer.
   assign w_count    = r_wrPtr - r_rdPtr;
   assign o_full     = (w_count == DEPTH_COUNT);
   assign o_empty    = (r_wrPtr == r_rdPtr);
   assign o_progFull = (w_count >= THRESH_COUNT);

   assign w_push = i_wrEn & ~o_full;
   assign w_pop  = i_rdEn & ~o_empty;

   assign o_rdData = r_mem[r_rdPtr[PTR_W-1:0]];

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr[PTR_W-1:0]] <= i_wrData;
      end
   end

   // Pointer bookkeeping; push and pop in the same cycle both take effect.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/tile_router_v1_00_a_input_port.sv
// ---------------------------------------------------------------------------
// tile_router_v1_00_a_input_port
//
// One router input port. Flits from the upstream link are buffered in a
// FWFT FIFO; the head flit of each packet selects a destination output port
// and the whole packet is then steered to that port (route locked until the
// flit marked "last" is accepted).
//
// Ports:
//   clk            - clock, rising edge
//   rst            - synchronous active-high reset
//   input_valid    - upstream flit valid
//   input_accept   - this port can take a flit (buffer not full, not in reset)
//   input_payload  - upstream flit
//   portX_valid    - one-hot valid, bit i goes to output port i
//   portX_accept   - per-output-port accept; only the routed bit is used
//   portX_payload  - buffered head flit, shared by all output ports
//   drop_count     - saturating count of discarded packets
//
// Configuration macro: TILE_ROUTER_INPUT_DROP_EN
//   defined   - a head flit addressing a port >= C_NUM_PORTS discards the
//               whole packet and bumps drop_count
//   undefined - such packets are steered to port C_NUM_PORTS-1 and
//               drop_count stays 0
// ---------------------------------------------------------------------------
module tile_router_v1_00_a_input_port
   import tile_router_v1_00_a_input_port_pkg::*;
#(
   parameter int C_NUM_PORTS    = 8,
   parameter int C_PACKET_WIDTH = PACKET_WIDTH,
   parameter int C_FIFO_DEPTH   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      input_valid,
   output logic                      input_accept,
   input  logic [C_PACKET_WIDTH-1:0] input_payload,
   output logic [C_NUM_PORTS-1:0]    portX_valid,
   input  logic [C_NUM_PORTS-1:0]    portX_accept,
   output logic [C_PACKET_WIDTH-1:0] portX_payload,
   output logic [15:0]               drop_count
);

   // A single-port router still needs a one-bit destination register.
   localparam int DEST_W = (clog2(C_NUM_PORTS) < 1) ? 1 : clog2(C_NUM_PORTS);

   state_t              r_state;
   logic [DEST_W-1:0]   r_dest;

   logic                      w_fifoFull;
   logic                      w_fifoEmpty;
   logic                      w_unusedProgFull;
   logic [C_PACKET_WIDTH-1:0] w_head;
   logic                      w_headLast;
   logic [DEST_W-1:0]         w_headDest;
   logic                      w_destInvalid;
   logic [DEST_W-1:0]         w_routedDest;
   logic                      w_headDrop;
   logic                      w_selAccept;
   logic                      w_pop;
   logic                      w_push;

   // Reset forces input_accept low so nothing is taken while the port clears.
   assign input_accept = ~w_fifoFull & ~rst;
   assign w_push       = input_valid & input_accept;

   fifo_fwft_prog_full #(
      .C_DATA_WIDTH       (C_PACKET_WIDTH),
      .C_DEPTH            (C_FIFO_DEPTH),
      .C_PROG_FULL_THRESH (C_FIFO_DEPTH - 2)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_wrEn     (w_push),
      .i_wrData   (input_payload),
      .o_full     (w_fifoFull),
      .o_progFull (w_unusedProgFull),
      .i_rdEn     (w_pop),
      .o_rdData   (w_head),
      .o_empty    (w_fifoEmpty)
   );

   assign w_headLast    = w_head[PKT_LAST_BIT];
   assign w_headDest    = w_head[PKT_DEST_LSB +: DEST_W];
   assign w_destInvalid = (int'(w_headDest) >= C_NUM_PORTS);

`ifdef TILE_ROUTER_INPUT_DROP_EN
   // Out-of-range destinations discard the packet.
   assign w_routedDest = w_headDest;
   assign w_headDrop   = w_destInvalid;
`else
   // Out-of-range destinations fall back to the highest-numbered port.
   assign w_routedDest = w_destInvalid ? DEST_W'(C_NUM_PORTS - 1) : w_headDest;
   assign w_headDrop   = 1'b0;
`endif

   // Only the accept of the locked destination matters; the others are
   // other input ports' business.
   assign w_selAccept = portX_accept[r_dest];

   // Pops happen only while forwarding with the destination accepting, or
   // unconditionally while discarding a packet.
   assign w_pop = ~w_fifoEmpty &
                  (((r_state == STATE_FWD) & w_selAccept) | (r_state == STATE_DROP));

   // One-hot steering of the head flit toward the locked destination.
   always_comb begin
      portX_valid = '0;
      if ((r_state == STATE_FWD) && !w_fifoEmpty) begin
         portX_valid[r_dest] = 1'b1;
      end
   end

   assign portX_payload = w_head;

   // Packet-level FSM: HEAD inspects a new head flit without popping it,
   // costing one bubble cycle per packet; FWD and DROP stream the packet
   // out until its last flit leaves the buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= STATE_HEAD;
         r_dest  <= '0;
      end else begin
         case (r_state)
            STATE_HEAD: begin
               if (!w_fifoEmpty) begin
                  r_dest  <= w_routedDest;
                  r_state <= w_headDrop ? STATE_DROP : STATE_FWD;
               end
            end
            STATE_FWD: begin
               if (w_pop && w_headLast) begin
                  r_state <= STATE_HEAD;
               end
            end
            STATE_DROP: begin
               if (w_pop && w_headLast) begin
                  r_state <= STATE_HEAD;
               end
            end
            default: begin
               r_state <= STATE_HEAD;
            end
         endcase
      end
   end

`ifdef TILE_ROUTER_INPUT_DROP_EN
   logic [15:0] r_dropCount;
   logic        w_dropDone;

   assign w_dropDone = (r_state == STATE_DROP) & w_pop & w_headLast;

   // Counts whole discarded packets, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dropCount <= '0;
      end else if (w_dropDone && (r_dropCount != 16'hFFFF)) begin
         r_dropCount <= r_dropCount + 16'd1;
      end
   end

   assign drop_count = r_dropCount;
`else
   assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_tile_router_v1_00_a_input_port.sv
// ---------------------------------------------------------------------------
// tb_tile_router_v1_00_a_input_port
//
// Self-checking bench for the router input port, built with 6 output ports
// so that destinations 6 and 7 are out of range. Works with and without
// TILE_ROUTER_INPUT_DROP_EN.
// ---------------------------------------------------------------------------
module tb_tile_router_v1_00_a_input_port;
   import tile_router_v1_00_a_input_port_pkg::*;

   localparam int NP = 6;
   localparam int PW = PACKET_WIDTH;
   localparam int DEPTH = 16;

`ifdef TILE_ROUTER_INPUT_DROP_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          input_valid;
   logic          input_accept;
   logic [PW-1:0] input_payload;
   logic [NP-1:0] portX_valid;
   logic [NP-1:0] portX_accept;
   logic [PW-1:0] portX_payload;
   logic [15:0]   drop_count;

   int testsRun;
   int testsFailed;
   int expDrops;

   tile_router_v1_00_a_input_port #(
      .C_NUM_PORTS    (NP),
      .C_PACKET_WIDTH (PW),
      .C_FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .input_valid   (input_valid),
      .input_accept  (input_accept),
      .input_payload (input_payload),
      .portX_valid   (portX_valid),
      .portX_accept  (portX_accept),
      .portX_payload (portX_payload),
      .drop_count    (drop_count)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something never returns.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [PW-1:0] payload,
                                input logic [NP-1:0] accept);
      input_valid   = valid;
      input_payload = payload;
      portX_accept  = accept;
   endtask

   function automatic logic [PW-1:0] makeFlit(input int dest, input bit last,
                                              input logic [23:0] data);
      logic [PW-1:0] f;
      f = PW'(data);
      f[PKT_DEST_LSB +: 3] = 3'(dest);
      f[PKT_LAST_BIT] = last;
      return f;
   endfunction

   // Where a packet addressed to dest should appear; -1 means discarded.
   function automatic int expectedPort(input int dest);
      if (dest < NP) return dest;
      if (DROP_EN) return -1;
      return NP - 1;
   endfunction

   // Called at a negedge; offers one flit until taken, returns at a negedge.
   task automatic pushFlit(input logic [PW-1:0] f);
      int waitCycles;
      waitCycles = 0;
      input_valid   = 1'b1;
      input_payload = f;
      while (!input_accept && waitCycles < 100) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("push_accept", 32'(input_accept), 32'd1);
      @(negedge clk);
      input_valid = 1'b0;
   endtask

   // Called at a negedge; raises accept on port, waits for the flit, checks it.
   task automatic collectFlit(input int port, input logic [PW-1:0] expFlit,
                              input string name);
      int waitCycles;
      waitCycles = 0;
      portX_accept[port] = 1'b1;
      while (!portX_valid[port] && waitCycles < 50) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput({name, "_valid"}, 32'(portX_valid), 32'(1 << port));
      checkOutput({name, "_payload"}, portX_payload, expFlit);
      @(negedge clk);
   endtask

   typedef struct {
      int            dest;
      logic [23:0]   data;
      logic [NP-1:0] expValid;
      int            expDropInc;
   } vec_t;

   initial begin
      vec_t          vecs[5];
      logic [PW-1:0] pkt[4];
      logic [PW-1:0] fill[DEPTH];
      logic [PW-1:0] drainQ[$];
      logic [PW-1:0] fB;
      logic [PW-1:0] fY;
      logic [PW-1:0] fZ;
      logic [NP-1:0] seen;
      int            nGot;
      logic [PW-1:0] toPush[$];
      int            expPort[$];
      logic [PW-1:0] expFlit[$];
      int            randDrops;

      // Single-flit packet table: accepts all high, one-cycle delivery expected.
      vecs[0] = '{3, 24'hA5A503, 6'h08, 0};
      vecs[1] = '{0, 24'h123400, 6'h01, 0};
      vecs[2] = '{5, 24'hC0FFEE, 6'h20, 0};
      vecs[3] = '{7, 24'h777777, DROP_EN ? 6'h00 : 6'h20, DROP_EN ? 1 : 0};
      vecs[4] = '{1, 24'h0B0B01, 6'h02, 0};

      testsRun    = 0;
      testsFailed = 0;
      expDrops    = 0;

      // Reset state.
      rst = 1'b1;
      applyStimulus(1'b0, '0, '0);
      repeat (3) @(negedge clk);
      checkOutput("reset_valid", 32'(portX_valid), 32'd0);
      checkOutput("reset_inAccept", 32'(input_accept), 32'd0);
      checkOutput("reset_dropCount", 32'(drop_count), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("postReset_inAccept", 32'(input_accept), 32'd1);
      checkOutput("postReset_valid", 32'(portX_valid), 32'd0);

      // Table-driven single-flit packets.
      for (int i = 0; i < 5; i++) begin
         portX_accept = '1;
         pushFlit(makeFlit(vecs[i].dest, 1'b1, vecs[i].data));
         expDrops += vecs[i].expDropInc;
         if (vecs[i].expValid != '0) begin
            nGot = 0;
            while (portX_valid == '0 && nGot < 20) begin
               @(negedge clk);
               nGot++;
            end
            checkOutput($sformatf("single%0d_valid", i), 32'(portX_valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("single%0d_payload", i), portX_payload,
                        makeFlit(vecs[i].dest, 1'b1, vecs[i].data));
            @(negedge clk);
            checkOutput($sformatf("single%0d_oneCycle", i), 32'(portX_valid), 32'd0);
         end else begin
            seen = '0;
            repeat (6) begin
               seen |= portX_valid;
               @(negedge clk);
            end
            checkOutput($sformatf("single%0d_noValid", i), 32'(seen), 32'd0);
         end
         checkOutput($sformatf("single%0d_dropCount", i), 32'(drop_count), 32'(expDrops));
      end

      // Held 4-flit packet to port 5; other accepts must not matter.
      for (int i = 0; i < 4; i++) begin
         pkt[i] = makeFlit((i == 0) ? 5 : 2, i == 3, 24'h500 + 24'(i));
      end
      portX_accept = 6'b011111;
      for (int i = 0; i < 4; i++) pushFlit(pkt[i]);
      for (int c = 0; c < 10; c++) begin
         checkOutput("hold_valid", 32'(portX_valid), 32'h20);
         checkOutput("hold_payload", portX_payload, pkt[0]);
         portX_accept[2] = ~portX_accept[2];
         @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
         collectFlit(5, pkt[i], $sformatf("hold_flit%0d", i));
         portX_accept[2] = ~portX_accept[2];
      end
      portX_accept = '0;
      checkOutput("hold_end_valid", 32'(portX_valid), 32'd0);

      // Fill the buffer, then probe full / push-while-full / push-with-pop.
      for (int i = 0; i < DEPTH; i++) begin
         fill[i] = makeFlit(1, 1'b0, 24'h100 + 24'(i));
         pushFlit(fill[i]);
      end
      fB = makeFlit(4, 1'b0, 24'hBBBBBB);
      fY = makeFlit(4, 1'b0, 24'hEEEEEE);
      fZ = makeFlit(4, 1'b1, 24'hDDDDDD);
      checkOutput("fill_full", 32'(input_accept), 32'd0);
      checkOutput("fill_valid", 32'(portX_valid), 32'h02);
      checkOutput("fill_headPayload", portX_payload, fill[0]);
      applyStimulus(1'b1, fB, 6'b000010);
      @(negedge clk);
      checkOutput("fill_afterPop", 32'(input_accept), 32'd1);
      @(negedge clk);
      checkOutput("fill_pushPop", 32'(input_accept), 32'd1);
      applyStimulus(1'b1, fY, 6'b000000);
      @(negedge clk);
      checkOutput("fill_refull", 32'(input_accept), 32'd0);
      input_valid = 1'b0;
      for (int i = 2; i < DEPTH; i++) drainQ.push_back(fill[i]);
      drainQ.push_back(fB);
      drainQ.push_back(fY);
      foreach (drainQ[i]) collectFlit(1, drainQ[i], $sformatf("drain%0d", i));
      pushFlit(fZ);
      collectFlit(1, fZ, "drain_last");
      portX_accept = '0;
      checkOutput("drain_end_valid", 32'(portX_valid), 32'd0);

      // 3-flit packet to out-of-range destination 7.
      for (int i = 0; i < 3; i++) pkt[i] = makeFlit(7, i == 2, 24'h700 + 24'(i));
      portX_accept = '0;
      for (int i = 0; i < 3; i++) pushFlit(pkt[i]);
      portX_accept = '1;
      nGot = 0;
      for (int c = 0; c < 12; c++) begin
         if (portX_valid != '0) begin
            checkOutput("dest7_valid", 32'(portX_valid), 32'(1 << (NP - 1)));
            checkOutput("dest7_payload", portX_payload, pkt[(nGot > 2) ? 2 : nGot]);
            nGot++;
         end
         @(negedge clk);
      end
      expDrops += (expectedPort(7) < 0) ? 1 : 0;
      checkOutput("dest7_count", 32'(nGot), (expectedPort(7) < 0) ? 32'd0 : 32'd3);
      checkOutput("dest7_dropCount", 32'(drop_count), 32'(expDrops));

      // Random packets against a packet-level scoreboard.
      randDrops = 0;
      for (int p = 0; p < 30; p++) begin
         int dest;
         int len;
         dest = int'($urandom_range(0, 7));
         len  = int'($urandom_range(1, 4));
         if (expectedPort(dest) < 0) randDrops++;
         for (int k = 0; k < len; k++) begin
            logic [PW-1:0] f;
            f = makeFlit((k == 0) ? dest : int'($urandom_range(0, 7)), k == len - 1,
                         {8'hA0, 8'(p), 8'(k)});
            toPush.push_back(f);
            if (expectedPort(dest) >= 0) begin
               expPort.push_back(expectedPort(dest));
               expFlit.push_back(f);
            end
         end
      end
      begin
         int            cycle;
         int            pushIdx;
         int            delivered;
         logic [NP-1:0] acc;
         logic [NP-1:0] hs;
         logic [NP-1:0] prevValid;
         logic [PW-1:0] prevPayload;
         bit            prevHeld;
         cycle     = 0;
         pushIdx   = 0;
         delivered = 0;
         prevHeld  = 1'b0;
         prevValid = '0;
         prevPayload = '0;
         while ((pushIdx < toPush.size() || delivered < expPort.size()) && cycle < 4000) begin
            if (prevHeld) begin
               checkOutput("rand_holdValid", 32'(portX_valid), 32'(prevValid));
               checkOutput("rand_holdPayload", portX_payload, prevPayload);
            end
            checkOutput("rand_oneHot", 32'($countones(portX_valid) <= 1), 32'd1);
            acc = NP'($urandom) | NP'($urandom);
            portX_accept = acc;
            if (pushIdx < toPush.size() && $urandom_range(0, 3) != 0) begin
               input_valid   = 1'b1;
               input_payload = toPush[pushIdx];
               if (input_accept) pushIdx++;
            end else begin
               input_valid = 1'b0;
            end
            hs = portX_valid & acc;
            if (hs != '0) begin
               int port;
               port = 0;
               for (int i = 0; i < NP; i++) if (hs[i]) port = i;
               if (delivered < expPort.size()) begin
                  checkOutput("rand_port", 32'(port), 32'(expPort[delivered]));
                  checkOutput("rand_payload", portX_payload, expFlit[delivered]);
               end else begin
                  checkOutput("rand_extraFlit", 32'(delivered), 32'(expPort.size()));
               end
               delivered++;
            end
            prevHeld    = (portX_valid != '0) && (hs == '0);
            prevValid   = portX_valid;
            prevPayload = portX_payload;
            @(negedge clk);
            cycle++;
         end
         input_valid = 1'b0;
         checkOutput("rand_allPushed", 32'(pushIdx), 32'(toPush.size()));
         checkOutput("rand_allDelivered", 32'(delivered), 32'(expPort.size()));
      end
      portX_accept = '1;
      repeat (40) @(negedge clk);
      expDrops += randDrops;
      checkOutput("rand_dropCount", 32'(drop_count), 32'(expDrops));
      checkOutput("rand_idleValid", 32'(portX_valid), 32'd0);

      // Reset in the middle of a 4-flit packet.
      for (int i = 0; i < 4; i++) pkt[i] = makeFlit((i == 0) ? 2 : 0, i == 3, 24'h200 + 24'(i));
      portX_accept = '0;
      for (int i = 0; i < 4; i++) pushFlit(pkt[i]);
      collectFlit(2, pkt[0], "midReset_flit0");
      collectFlit(2, pkt[1], "midReset_flit1");
      portX_accept = '0;
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midReset_valid", 32'(portX_valid), 32'd0);
      checkOutput("midReset_inAccept", 32'(input_accept), 32'd0);
      checkOutput("midReset_dropCount", 32'(drop_count), 32'd0);
      expDrops = 0;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("afterReset_inAccept", 32'(input_accept), 32'd1);
      checkOutput("afterReset_valid", 32'(portX_valid), 32'd0);
      portX_accept = '1;
      fZ = makeFlit(0, 1'b1, 24'h0F0F0F);
      pushFlit(fZ);
      collectFlit(0, fZ, "afterReset_pkt");
      checkOutput("afterReset_idle", 32'(portX_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
